// File: rtl/pll_reset_gen.sv
// PLL lock consumer: synchronizes the asynchronous lock flag, waits out a stabilization
// window, then releases a synchronous active-low reset; filters glitches and counts losses.
module pll_reset_gen #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       lock,
  input  logic       clear_count,
  output logic       sys_rstn,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] loss_count,
  output logic [1:0] pll_state
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STABLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [SW-1:0]          stable_cnt, stable_cnt_nxt;
  logic [GW-1:0]          glitch_cnt, glitch_cnt_nxt;
  logic                   loss;

  // Only the first flop of this chain ever sees the raw asynchronous lock.
  always_ff @(posedge clk) begin
    if (!rstn) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], lock};
  end

  assign lock_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt      = state;
    stable_cnt_nxt = stable_cnt;
    glitch_cnt_nxt = glitch_cnt;
    loss           = 1'b0;
    case (state)
      IDLE: begin
        stable_cnt_nxt = '0;
        glitch_cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt      = IDLE;
          stable_cnt_nxt = '0;
        end else if (stable_cnt == STABLE_LAST) begin
          state_nxt      = RUN;
          stable_cnt_nxt = '0;
          glitch_cnt_nxt = '0;
        end else begin
          stable_cnt_nxt = stable_cnt + 1'b1;
        end
      end
      RUN: begin
        if (lock_s) begin
          glitch_cnt_nxt = '0;
        end else if (glitch_cnt == GLITCH_LAST) begin
          state_nxt      = IDLE;
          glitch_cnt_nxt = '0;
          loss           = 1'b1;
        end else begin
          glitch_cnt_nxt = glitch_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt      = IDLE;
        stable_cnt_nxt = '0;
        glitch_cnt_nxt = '0;
      end
    endcase
  end

  // loss_count steps on the same edge that raises lock_lost, so a clear in that
  // cycle lands on 1 rather than 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      stable_cnt <= '0;
      glitch_cnt <= '0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= stable_cnt_nxt;
      glitch_cnt <= glitch_cnt_nxt;
      lock_lost  <= loss;
      if (clear_count)                   loss_count <= {7'd0, loss};
      else if (loss && loss_count != '1) loss_count <= loss_count + 8'd1;
    end
  end

  assign sys_rstn  = (state == RUN);
  assign ready     = (state == RUN);
  assign pll_state = state;

endmodule

// File: tb/tb_pll_reset_gen.sv
// Scoreboarded bench for pll_reset_gen: stimulus pushes model predictions per edge,
// an independent monitor pops and compares after every clock edge.
module tb_pll_reset_gen;

  localparam int SYNC = 2;
  localparam int STAB = 16;
  localparam int GL   = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       lock = 1'b0;
  logic       clear_count = 1'b0;
  logic       sys_rstn, ready, lock_lost;
  logic [7:0] loss_count;
  logic [1:0] pll_state;

  always #5 clk = ~clk;

  pll_reset_gen #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB),
    .GLITCH_CYCLES(GL)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .lock       (lock),
    .clear_count(clear_count),
    .sys_rstn   (sys_rstn),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .loss_count (loss_count),
    .pll_state  (pll_state)
  );

  typedef struct packed {
    logic       sys_rstn;
    logic       ready;
    logic       lock_lost;
    logic [7:0] cnt;
    logic [1:0] st;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   async_mode = 0;

  // Reference model: lock samples delayed by SYNC edges, then run-length rules.
  bit pipe[$];
  int hi_run, lo_run, m_cnt;
  bit m_run, m_lost;

  function automatic obs_t model_step(bit r, bit l, bit c);
    obs_t o;
    bit   ls;
    if (!r) begin
      pipe.delete();
      for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
      hi_run = 0; lo_run = 0; m_cnt = 0; m_run = 0; m_lost = 0;
    end else begin
      ls = pipe[$];
      pipe.pop_back();
      pipe.push_front(l);
      m_lost = 0;
      if (m_run) begin
        lo_run = ls ? 0 : lo_run + 1;
        if (lo_run == GL) begin
          m_run = 0; m_lost = 1; hi_run = 0; lo_run = 0;
        end
      end else begin
        hi_run = ls ? hi_run + 1 : 0;
        if (hi_run == STAB + 1) begin
          m_run = 1; lo_run = 0;
        end
      end
      if (c)           m_cnt = m_lost ? 1 : 0;
      else if (m_lost) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end
    o.sys_rstn  = m_run;
    o.ready     = m_run;
    o.lock_lost = m_lost;
    o.cnt       = 8'(m_cnt);
    o.st        = m_run ? 2'd2 : (hi_run > 0 ? 2'd1 : 2'd0);
    return o;
  endfunction

  task automatic cycle(input bit r, input bit l, input bit c);
    @(negedge clk);
    rstn = r; lock = l; clear_count = c;
    exp_q.push_back(model_step(r, l, c));
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Edges from the first high lock sample until sys_rstn is seen high (-1 if never).
  task automatic wait_release(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(1, 1, 0);
      @(posedge clk); #1;
      if (sys_rstn === 1'b1) begin n = i; break; end
    end
  endtask

  obs_t act, ex;
  initial forever begin
    @(posedge clk); #1;
    act = {sys_rstn, ready, lock_lost, loss_count, pll_state};
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      checks++;
      if (act === ex) passed++;
      else $display("FAIL scoreboard t=%0t: got sys_rstn=%b ready=%b lost=%b cnt=%0d st=%0d want sys_rstn=%b ready=%b lost=%b cnt=%0d st=%0d",
                    $time, act.sys_rstn, act.ready, act.lock_lost, act.cnt, act.st,
                    ex.sys_rstn, ex.ready, ex.lock_lost, ex.cnt, ex.st);
    end else if (async_mode) begin
      checks++;
      if (!$isunknown(act) && pll_state != 2'd3) passed++;
      else $display("FAIL async_sanity t=%0t: got outputs=%b want no X and state!=3", $time, act);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    // Power-up reset with lock already high
    repeat (3) cycle(0, 1, 0);
    @(posedge clk); #1;
    chk("reset_outputs", int'({sys_rstn, ready, lock_lost, loss_count, pll_state}), 0);
    wait_release(n);
    chk("powerup_release_edges", n, SYNC + STAB + 1);
    chk("run_state", int'(pll_state), 2);

    // Drop inside STABLE at count 10: not a loss; re-lock takes the full window
    repeat (4) cycle(0, 0, 0);
    repeat (SYNC + 1 + 10) cycle(1, 1, 0);
    repeat (4) cycle(1, 0, 0);
    @(posedge clk); #1;
    chk("stable_drop_state", int'(pll_state), 0);
    chk("stable_drop_count", int'(loss_count), 0);
    wait_release(n);
    chk("relock_release_edges", n, SYNC + STAB + 1);

    // Short glitch ignored, full-length glitch is a loss
    repeat (GL - 1) cycle(1, 0, 0);
    repeat (6) cycle(1, 1, 0);
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(1, (i <= GL) ? 1'b0 : 1'b1, 0);
      @(posedge clk); #1;
      if (sys_rstn === 1'b0 && n < 0) n = i;
    end
    chk("loss_latency_edges", n, SYNC + GL);
    chk("loss_count_one", int'(loss_count), 1);

    // Saturation from a clean count
    repeat (2) cycle(0, 0, 0);
    for (int k = 0; k < 256; k++) begin
      wait_release(n);
      if (n < 0) chk("sat_release_timeout", n, SYNC + STAB + 1);
      repeat (SYNC + GL) cycle(1, 0, 0);
    end
    @(posedge clk); #1;
    chk("loss_count_saturated", int'(loss_count), 255);

    // Clear held across a loss edge leaves exactly that one loss counted
    wait_release(n);
    repeat (SYNC + GL) cycle(1, 0, 1);
    cycle(1, 0, 0);
    @(posedge clk); #1;
    chk("clear_with_loss", int'(loss_count), 1);

    // Reset mid-RUN: immediate drop, counter cleared, no loss pulse
    wait_release(n);
    cycle(0, 1, 0);
    @(posedge clk); #1;
    chk("midrun_reset_sys_rstn", int'(sys_rstn), 0);
    chk("midrun_reset_count", int'(loss_count), 0);
    chk("midrun_reset_lost", int'(lock_lost), 0);
    cycle(0, 1, 0);
    wait_release(n);
    chk("midrun_rerelease_edges", n, SYNC + STAB + 1);

    // Randomized RUN-domain traffic: glitches of random length, random clears/resets
    for (int k = 0; k < 60; k++) begin
      int hi_len, lo_len;
      hi_len = $urandom_range(1, 24);
      lo_len = $urandom_range(1, 6);
      for (int i = 0; i < hi_len; i++)
        cycle(($urandom_range(0, 99) != 0), 1, ($urandom_range(0, 15) == 0));
      for (int i = 0; i < lo_len; i++)
        cycle(1, 0, ($urandom_range(0, 15) == 0));
    end

    // Asynchronous lock toggling with random phase
    @(negedge clk);
    rstn = 1; clear_count = 0;
    async_mode = 1;
    for (int i = 0; i < 400; i++) begin
      #($urandom_range(1, 37));
      lock = ($urandom_range(0, 3) != 0) ? ~lock : lock;
    end
    async_mode = 0;
    repeat (2) cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
